// File: rtl/shifter_arbiter.sv
// shifter_arbiter
//   Shares the core's single 32-bit barrel shifter between two requesters:
//   requester 0 = execute-stage ALU shifts, requester 1 = load/store byte-lane
//   alignment. Round-robin arbitration, valid/ready on both request ports,
//   result registered in a single-entry output buffer tagged with the winner.
//
// Ports
//   clk_i                      core clock, all state on rising edge
//   reset_i                    synchronous, active-high reset
//   req_valid_i[1:0]           per-requester request valid
//   req_ready_o[1:0]           per-requester accept (combinational)
//   req_in_i[63:0]             operand, [32i+31:32i] belongs to requester i
//   req_amount_i[9:0]          shift amount, [5i+4:5i] belongs to requester i
//   req_is_right_i[1:0]        right shift per requester
//   req_is_right_arithmetic_i  arithmetic right shift per requester
//   resp_valid_o               output buffer holds a result
//   resp_ready_i               consumer accepts the result
//   resp_id_o                  requester that produced resp_data_o
//   resp_data_o[31:0]          shift result
//
// Optional build macro SHIFTER_ARB_STATS_EN adds stat_grants0_o,
// stat_grants1_o (accepted requests per requester) and stat_stall_o (cycles
// with a pending request but no grant). Counters wrap at 2^32.

module shifter_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_BITS = 1
) (
   input  logic                 clk_i,
   input  logic                 reset_i,
   input  logic [NUM_REQ-1:0]   req_valid_i,
   output logic [NUM_REQ-1:0]   req_ready_o,
   input  logic [NUM_REQ*32-1:0] req_in_i,
   input  logic [NUM_REQ*5-1:0] req_amount_i,
   input  logic [NUM_REQ-1:0]   req_is_right_i,
   input  logic [NUM_REQ-1:0]   req_is_right_arithmetic_i,
   output logic                 resp_valid_o,
   input  logic                 resp_ready_i,
   output logic [ID_BITS-1:0]   resp_id_o,
   output logic [31:0]          resp_data_o
`ifdef SHIFTER_ARB_STATS_EN
   ,
   output logic [31:0]          stat_grants0_o,
   output logic [31:0]          stat_grants1_o,
   output logic [31:0]          stat_stall_o
`endif
);

   generate
      if (NUM_REQ != 2) begin : g_bad_num_req
         $error("shifter_arbiter supports exactly NUM_REQ = 2");
      end
   endgenerate

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

   state_e               state_q, state_d;
   logic                 rr_prio_q, rr_prio_d;
   logic [ID_BITS-1:0]   id_q, id_d;
   logic [31:0]          data_q, data_d;

   logic                 can_accept, grant, grant_id;
   logic [31:0]          op_in, shift_res;
   logic [4:0]           op_amt;
   logic                 op_right, op_arith;

   // Arbitration: favoured requester wins a tie, a lone requester always wins.
   // Reset gating keeps req_ready low during the reset cycle.
   assign can_accept = (state_q == EMPTY) | resp_ready_i;
   assign grant      = can_accept & (|req_valid_i) & ~reset_i;
   assign grant_id   = (&req_valid_i) ? rr_prio_q : req_valid_i[1];

   assign req_ready_o[0] = grant & ~grant_id;
   assign req_ready_o[1] = grant &  grant_id;

   // Winner's payload drives the shared shifter
   assign op_in    = grant_id ? req_in_i[63:32] : req_in_i[31:0];
   assign op_amt   = grant_id ? req_amount_i[9:5] : req_amount_i[4:0];
   assign op_right = req_is_right_i[grant_id];
   // Arithmetic only means something for right shifts; otherwise logical left
   assign op_arith = req_is_right_arithmetic_i[grant_id] & op_right;

   always_comb begin
      shift_res = op_in << op_amt;
      if (op_right)
         shift_res = op_arith ? 32'($signed(op_in) >>> op_amt) : (op_in >> op_amt);
   end

   always_comb begin
      state_d   = state_q;
      rr_prio_d = rr_prio_q;
      id_d      = id_q;
      data_d    = data_q;
      if (grant) begin
         rr_prio_d = ~grant_id;
         id_d      = ID_BITS'(grant_id);
         data_d    = shift_res;
      end
      case (state_q)
         EMPTY:   if (grant) state_d = FULL;
         FULL:    if (resp_ready_i && !grant) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q   <= EMPTY;
         rr_prio_q <= 1'b0;
         id_q      <= '0;
         data_q    <= '0;
      end else begin
         state_q   <= state_d;
         rr_prio_q <= rr_prio_d;
         id_q      <= id_d;
         data_q    <= data_d;
      end
   end

   assign resp_valid_o = (state_q == FULL);
   assign resp_id_o    = id_q;
   assign resp_data_o  = data_q;

`ifdef SHIFTER_ARB_STATS_EN
   logic [31:0] g0_q, g1_q, stall_q;

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         g0_q    <= '0;
         g1_q    <= '0;
         stall_q <= '0;
      end else begin
         if (req_ready_o[0]) g0_q <= g0_q + 32'd1;
         if (req_ready_o[1]) g1_q <= g1_q + 32'd1;
         if ((|req_valid_i) && !grant) stall_q <= stall_q + 32'd1;
      end
   end

   assign stat_grants0_o = g0_q;
   assign stat_grants1_o = g1_q;
   assign stat_stall_o   = stall_q;
`endif

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed testbench for shifter_arbiter. Inputs change 1 time unit after the
// rising edge; all observations are taken on the falling edge.

module tb_shifter_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [31:0] in0, in1;
   logic [4:0]  amt0, amt1;
   logic [1:0]  is_right, is_arith;
   logic        resp_valid, resp_ready, resp_id;
   logic [31:0] resp_data;
   logic [63:0] req_in;
   logic [9:0]  req_amount;
`ifdef SHIFTER_ARB_STATS_EN
   logic [31:0] st_g0, st_g1, st_stall;
`endif

   int vecs = 0;
   int errs = 0;

   assign req_in     = {in1, in0};
   assign req_amount = {amt1, amt0};

   always #5 clk = ~clk;

   shifter_arbiter dut (
      .clk_i                     (clk),
      .reset_i                   (reset),
      .req_valid_i               (req_valid),
      .req_ready_o               (req_ready),
      .req_in_i                  (req_in),
      .req_amount_i              (req_amount),
      .req_is_right_i            (is_right),
      .req_is_right_arithmetic_i (is_arith),
      .resp_valid_o              (resp_valid),
      .resp_ready_i              (resp_ready),
      .resp_id_o                 (resp_id),
      .resp_data_o               (resp_data)
`ifdef SHIFTER_ARB_STATS_EN
      ,
      .stat_grants0_o            (st_g0),
      .stat_grants1_o            (st_g1),
      .stat_stall_o              (st_stall)
`endif
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic resp(input string tag, input logic v, input logic id, input logic [31:0] d);
      chk({tag, ".valid"}, {31'd0, resp_valid}, {31'd0, v});
      if (v) begin
         chk({tag, ".id"},   {31'd0, resp_id},    {31'd0, id});
         chk({tag, ".data"}, resp_data, d);
      end
   endtask

   task automatic rdy(input string tag, input logic [1:0] e);
      chk({tag, ".ready"}, {30'd0, req_ready}, {30'd0, e});
   endtask

   // advance to just after the next rising edge / to the falling edge
   task automatic nxt(); @(posedge clk); #1; endtask
   task automatic mid(); @(negedge clk); endtask

   initial begin
      reset = 1'b1; req_valid = 2'b11; resp_ready = 1'b1;
      in0 = '0; in1 = '0; amt0 = '0; amt1 = '0; is_right = '0; is_arith = '0;

      // ---- reset state (requests pending, nothing accepted)
      nxt(); mid();
      rdy("rst", 2'b00);
      chk("rst.valid", {31'd0, resp_valid}, 32'd0);
      chk("rst.id",    {31'd0, resp_id},    32'd0);
      chk("rst.data",  resp_data,           32'd0);

      // ---- single request, logical left
      nxt(); reset = 1'b0; req_valid = 2'b01;
      in0 = 32'h8000_0001; amt0 = 5'd4; is_right = 2'b00; is_arith = 2'b00;
      mid(); rdy("single", 2'b01);
      nxt(); req_valid = 2'b00;
      mid(); resp("single", 1'b1, 1'b0, 32'h0000_0010); rdy("single.idle", 2'b00);

      // ---- fresh reset so rr_prio starts at 0, then alternation
      nxt(); reset = 1'b1;
      nxt(); reset = 1'b0; req_valid = 2'b11;
      in0 = 32'hF000_0000; amt0 = 5'd4;
      in1 = 32'h0000_FF00; amt1 = 5'd8;
      is_right = 2'b11; is_arith = 2'b01;
      mid(); rdy("alt0", 2'b01); resp("alt0", 1'b0, 1'b0, 32'h0);
      nxt(); mid(); rdy("alt1", 2'b10); resp("alt1", 1'b1, 1'b0, 32'hFF00_0000);
      nxt(); mid(); rdy("alt2", 2'b01); resp("alt2", 1'b1, 1'b1, 32'h0000_00FF);
      nxt(); mid(); rdy("alt3", 2'b10); resp("alt3", 1'b1, 1'b0, 32'hFF00_0000);
      nxt(); req_valid = 2'b00;
      mid(); rdy("alt4", 2'b00); resp("alt4", 1'b1, 1'b1, 32'h0000_00FF);
      nxt(); mid(); resp("drain", 1'b0, 1'b0, 32'h0);

      // ---- back-pressure: result held 3 cycles while req1 waits
      nxt(); req_valid = 2'b01; resp_ready = 1'b0;
      mid(); rdy("hold.acc", 2'b01);
      nxt(); req_valid = 2'b10;
      for (int i = 0; i < 3; i++) begin
         mid(); rdy("hold", 2'b00); resp("hold", 1'b1, 1'b0, 32'hFF00_0000);
         if (i < 2) nxt();
      end
      nxt(); resp_ready = 1'b1;
      mid(); rdy("release", 2'b10); resp("release", 1'b1, 1'b0, 32'hFF00_0000);
      nxt(); req_valid = 2'b00;
      mid(); resp("release.res", 1'b1, 1'b1, 32'h0000_00FF);

      // ---- arithmetic masked without right -> logical left; boundary amounts
      nxt(); req_valid = 2'b01; in0 = 32'h8000_0000; amt0 = 5'd1;
      is_right = 2'b00; is_arith = 2'b01;
      mid(); rdy("mask", 2'b01);
      nxt(); amt0 = 5'd31; is_right = 2'b01;
      mid(); resp("mask", 1'b1, 1'b0, 32'h0000_0000);
      nxt(); amt0 = 5'd0; in0 = 32'h1234_5678;
      mid(); resp("amt31", 1'b1, 1'b0, 32'hFFFF_FFFF);
      nxt(); is_arith = 2'b00;
      mid(); resp("amt0.arith", 1'b1, 1'b0, 32'h1234_5678);
      nxt(); is_right = 2'b00;
      mid(); resp("amt0.right", 1'b1, 1'b0, 32'h1234_5678);
      nxt(); req_valid = 2'b00;
      mid(); resp("amt0.left", 1'b1, 1'b0, 32'h1234_5678);

      // ---- reset while FULL with both requesters valid
      // last grant was req0, so rr_prio=1 here and req1 wins
      nxt(); req_valid = 2'b11; in1 = 32'h0000_FF00; amt1 = 5'd8; is_right = 2'b10;
      mid(); rdy("prerst", 2'b10);
      nxt(); reset = 1'b1;
      mid(); rdy("inrst", 2'b00); resp("inrst", 1'b1, 1'b1, 32'h0000_00FF);
      nxt(); reset = 1'b0;
      mid(); resp("postrst", 1'b0, 1'b0, 32'h0); rdy("postrst", 2'b01);
      nxt(); req_valid = 2'b00;
      mid(); resp("postrst.res", 1'b1, 1'b0, 32'h1234_5678);

`ifdef SHIFTER_ARB_STATS_EN
      // ---- counters: 10 alternating grants then 2 stall cycles
      nxt(); reset = 1'b1;
      nxt(); reset = 1'b0; req_valid = 2'b11; resp_ready = 1'b1;
      for (int i = 0; i < 9; i++) nxt();
      nxt(); resp_ready = 1'b0;
      nxt();
      nxt(); req_valid = 2'b00;
      mid();
      chk("stat.g0",    st_g0,    32'd5);
      chk("stat.g1",    st_g1,    32'd5);
      chk("stat.stall", st_stall, 32'd2);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

   // hard stop in case the sequence ever stalls
   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
